// File: rtl/wb_rom_loader.sv
// Boot sequencer: halts the CPU, streams a byte image into ROM over wishbone, then pulses reset.
// Optional read-back check of every byte is enabled by defining WB_ROM_LOADER_VERIFY_EN.
module wb_rom_loader #(
  parameter int NUM_ROMS     = 1,
  parameter int ROM_BYTES    = 256,
  parameter int ACK_TIMEOUT  = 16,
  parameter int RESET_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        sys_halt,
  output logic        sys_reset,
  output logic [31:0] wb_addr_o,
  output logic [31:0] wb_data_o,
  output logic        wb_cyc_o,
  output logic        wb_strobe_o,
  output logic        wb_we_o,
  input  logic [31:0] wb_data_i,
  input  logic        wb_ack_i,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [3:0]  dbg_state
);

  localparam int TOTAL  = NUM_ROMS * ROM_BYTES;
  localparam int CNT_W  = 13;
  localparam int WAIT_W = 16;
  localparam int OFF_W  = (ROM_BYTES > 1) ? $clog2(ROM_BYTES) : 0;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_HALT   = 4'd1,
    S_FETCH  = 4'd2,
    S_WRITE  = 4'd3,
    S_NEXT   = 4'd5,
    S_BOOT   = 4'd6,
    S_DONE   = 4'd7,
    S_ERROR  = 4'd8
`ifdef WB_ROM_LOADER_VERIFY_EN
    , S_VERIFY = 4'd4
`endif
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CNT_W-1:0]    r_count;
  logic [7:0]          r_byte;
  logic [WAIT_W-1:0]   r_wait;
  logic [CNT_W-1:0]    w_shift;
  logic [CNT_W-1:0]    w_off_full;
  logic [3:0]          w_chip;
  logic [7:0]          w_off;
  logic                w_timeout;
  logic                w_unused;

  // Chip and offset are pure bit slices of the linear byte index.
  assign w_shift    = r_count >> OFF_W;
  assign w_off_full = r_count & CNT_W'(ROM_BYTES - 1);
  assign w_chip     = w_shift[3:0];
  assign w_off      = w_off_full[7:0];
  assign w_timeout  = (r_wait == WAIT_W'(ACK_TIMEOUT - 1));

`ifdef WB_ROM_LOADER_VERIFY_EN
  assign w_unused = ^{wb_data_i[31:8], w_shift[CNT_W-1:4], w_off_full[CNT_W-1:8]};
`else
  assign w_unused = ^{wb_data_i, w_shift[CNT_W-1:4], w_off_full[CNT_W-1:8]};
`endif

  // r_wait restarts on every state change; it times both ack waits and the boot reset pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_byte  <= '0;
      r_wait  <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) r_wait <= '0;
      else                   r_wait <= r_wait + WAIT_W'(1);
      if (r_state == S_FETCH && byte_valid) r_byte <= byte_data;
      if (w_next == S_HALT)                 r_count <= '0;
      else if (r_state == S_NEXT)           r_count <= r_count + CNT_W'(1);
    end
  end

  // Image bytes follow valid/ready: a byte transfers on a clock edge where byte_valid and
  // byte_ready are both high; byte_ready is high only in FETCH and never depends on byte_valid.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: if (start) w_next = S_HALT;
      S_HALT:  w_next = S_FETCH;
      S_FETCH: if (byte_valid) w_next = S_WRITE;
      S_WRITE: begin
        if (wb_ack_i) begin
`ifdef WB_ROM_LOADER_VERIFY_EN
          w_next = S_VERIFY;
`else
          w_next = S_NEXT;
`endif
        end else if (w_timeout) begin
          w_next = S_ERROR;
        end
      end
`ifdef WB_ROM_LOADER_VERIFY_EN
      S_VERIFY: begin
        if (wb_ack_i)       w_next = (wb_data_i[7:0] == r_byte) ? S_NEXT : S_ERROR;
        else if (w_timeout) w_next = S_ERROR;
      end
`endif
      S_NEXT:  w_next = (r_count == CNT_W'(TOTAL - 1)) ? S_BOOT : S_FETCH;
      S_BOOT:  if (r_wait == WAIT_W'(RESET_CYCLES - 1)) w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    byte_ready  = (r_state == S_FETCH);
    wb_we_o     = (r_state == S_WRITE);
`ifdef WB_ROM_LOADER_VERIFY_EN
    wb_cyc_o    = (r_state == S_WRITE) || (r_state == S_VERIFY);
`else
    wb_cyc_o    = (r_state == S_WRITE);
`endif
    wb_strobe_o = wb_cyc_o;
    wb_addr_o   = {16'h0, w_chip, w_off, 2'b00};
    wb_data_o   = {24'h0, r_byte};
    sys_reset   = (r_state == S_BOOT);
    // Halt is held in ERROR so the CPU never runs a partial image.
    sys_halt    = !(r_state == S_IDLE || r_state == S_DONE);
    busy        = !(r_state == S_IDLE || r_state == S_DONE || r_state == S_ERROR);
    done        = (r_state == S_DONE);
    error       = (r_state == S_ERROR);
    dbg_state   = r_state;
  end

endmodule
